// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter
// Arbitrates the single register-file write port between the in-order
// writeback stage and a long-latency unit (divider / multicycle ops).
// LLU results go into a 2-entry FIFO. The pipeline normally wins the
// write port. If the buffered LLU head loses STARVE_LIMIT cycles in a row,
// the arbiter switches to FORCE: it stalls the pipeline and drains the
// FIFO, one entry per cycle.
//
// Ports
//   i_riscv_wbarb_clk / i_riscv_wbarb_rst_n : clock, async active-low reset
//   i_riscv_wbarb_pipe_wen/_rd/_data        : pipeline write request
//   i_riscv_wbarb_llu_valid/_rd/_data       : LLU result (push when ready)
//   o_riscv_wbarb_llu_ready                 : FIFO has room
//   i_riscv_wbarb_flush                     : trap flush, drops LLU entries
//   o_riscv_wbarb_stall_pipe                : writeback must hold (FORCE)
//   o_riscv_wbarb_rf_wen/_rd/_data          : registered RF write port
//   o_riscv_wbarb_llu_pending               : FIFO non-empty
module riscv_wb_arbiter #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned DEPTH        = 2
) (
  input  logic            i_riscv_wbarb_clk,
  input  logic            i_riscv_wbarb_rst_n,
  input  logic            i_riscv_wbarb_pipe_wen,
  input  logic [4:0]      i_riscv_wbarb_pipe_rd,
  input  logic [XLEN-1:0] i_riscv_wbarb_pipe_data,
  input  logic            i_riscv_wbarb_llu_valid,
  input  logic [4:0]      i_riscv_wbarb_llu_rd,
  input  logic [XLEN-1:0] i_riscv_wbarb_llu_data,
  output logic            o_riscv_wbarb_llu_ready,
  input  logic            i_riscv_wbarb_flush,
  output logic            o_riscv_wbarb_stall_pipe,
  output logic            o_riscv_wbarb_rf_wen,
  output logic [4:0]      o_riscv_wbarb_rf_rd,
  output logic [XLEN-1:0] o_riscv_wbarb_rf_data,
  output logic            o_riscv_wbarb_llu_pending
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  localparam logic [1:0]    FULL  = 2'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FORCE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        count_q, count_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [4:0]        fifo_rd_q   [2];
  logic [4:0]        fifo_rd_d   [2];
  logic [XLEN-1:0]   fifo_data_q [2];
  logic [XLEN-1:0]   fifo_data_d [2];
  logic              rf_wen_q, rf_wen_d;
  logic [4:0]        rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]   rf_data_q, rf_data_d;
  logic              stall_q, stall_d;

  logic              llu_ready;
  logic              push;
  logic              grant_pipe;
  logic              grant_llu;

  assign llu_ready = (count_q < FULL);
  assign push      = i_riscv_wbarb_llu_valid && llu_ready;

  always_comb begin
    grant_pipe = 1'b0;
    grant_llu  = 1'b0;
    if (state_q == FORCE) begin
      grant_llu = (count_q != 2'd0);
    end else begin
      grant_pipe = i_riscv_wbarb_pipe_wen;
      grant_llu  = !i_riscv_wbarb_pipe_wen && (count_q != 2'd0);
    end
  end

  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    count_d     = count_q;
    starve_d    = starve_q;
    state_d     = state_q;

    // FIFO is a shift register: slot 0 is always the head. Pop first, then
    // the push lands in the first free slot after the pop.
    if (grant_llu) begin
      fifo_rd_d[0]   = fifo_rd_q[1];
      fifo_data_d[0] = fifo_data_q[1];
      count_d        = count_q - 2'd1;
    end
    if (push) begin
      fifo_rd_d[count_d[0]]   = i_riscv_wbarb_llu_rd;
      fifo_data_d[count_d[0]] = i_riscv_wbarb_llu_data;
      count_d                 = count_d + 2'd1;
    end

    if (i_riscv_wbarb_flush) begin
      count_d  = 2'd0;
      starve_d = '0;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (push) state_d = WAIT;
        end
        WAIT: begin
          if (grant_llu) begin
            starve_d = '0;
          end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 1'b1;
          end
          if (count_d == 2'd0) begin
            state_d = IDLE;
          end else if (starve_d == LIMIT) begin
            state_d = FORCE;
          end
        end
        FORCE: begin
          if (grant_llu) starve_d = '0;
          if (count_d == 2'd0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Write-port mux. An LLU head granted in a flush cycle is discarded along
  // with the rest of the buffer; a pipeline grant is still committed.
  always_comb begin
    rf_wen_d  = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (grant_pipe) begin
      rf_wen_d  = (i_riscv_wbarb_pipe_rd != 5'd0);
      rf_rd_d   = i_riscv_wbarb_pipe_rd;
      rf_data_d = i_riscv_wbarb_pipe_data;
    end else if (grant_llu && !i_riscv_wbarb_flush) begin
      rf_wen_d  = (fifo_rd_q[0] != 5'd0);
      rf_rd_d   = fifo_rd_q[0];
      rf_data_d = fifo_data_q[0];
    end
    stall_d = (state_d == FORCE);
  end

  always_ff @(posedge i_riscv_wbarb_clk or negedge i_riscv_wbarb_rst_n) begin
    if (!i_riscv_wbarb_rst_n) begin
      state_q     <= IDLE;
      count_q     <= 2'd0;
      starve_q    <= '0;
      fifo_rd_q   <= '{default: '0};
      fifo_data_q <= '{default: '0};
      rf_wen_q    <= 1'b0;
      rf_rd_q     <= '0;
      rf_data_q   <= '0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
      rf_wen_q    <= rf_wen_d;
      rf_rd_q     <= rf_rd_d;
      rf_data_q   <= rf_data_d;
      stall_q     <= stall_d;
    end
  end

  assign o_riscv_wbarb_llu_ready   = llu_ready;
  assign o_riscv_wbarb_llu_pending = (count_q != 2'd0);
  assign o_riscv_wbarb_stall_pipe  = stall_q;
  assign o_riscv_wbarb_rf_wen      = rf_wen_q;
  assign o_riscv_wbarb_rf_rd       = rf_rd_q;
  assign o_riscv_wbarb_rf_data     = rf_data_q;

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Self-checking bench for riscv_wb_arbiter: directed scenarios followed by
// random traffic, all checked every cycle against a queue-based model.
module tb_riscv_wb_arbiter;

  localparam int unsigned XLEN = 64;
  localparam int unsigned LIM  = 4;

  logic            clk;
  logic            rst_n;
  logic            pipe_wen;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            llu_valid;
  logic [4:0]      llu_rd;
  logic [XLEN-1:0] llu_data;
  logic            llu_ready;
  logic            flush;
  logic            stall_pipe;
  logic            rf_wen;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_data;
  logic            llu_pending;

  riscv_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIM), .DEPTH(2)) dut (
    .i_riscv_wbarb_clk        (clk),
    .i_riscv_wbarb_rst_n      (rst_n),
    .i_riscv_wbarb_pipe_wen   (pipe_wen),
    .i_riscv_wbarb_pipe_rd    (pipe_rd),
    .i_riscv_wbarb_pipe_data  (pipe_data),
    .i_riscv_wbarb_llu_valid  (llu_valid),
    .i_riscv_wbarb_llu_rd     (llu_rd),
    .i_riscv_wbarb_llu_data   (llu_data),
    .o_riscv_wbarb_llu_ready  (llu_ready),
    .i_riscv_wbarb_flush      (flush),
    .o_riscv_wbarb_stall_pipe (stall_pipe),
    .o_riscv_wbarb_rf_wen     (rf_wen),
    .o_riscv_wbarb_rf_rd      (rf_rd),
    .o_riscv_wbarb_rf_data    (rf_data),
    .o_riscv_wbarb_llu_pending(llu_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: buffered results as a queue of {rd, data}, a flag for
  // "LLU has priority" mode, and a count of consecutive lost cycles.
  logic [68:0]     q[$];
  bit              frc;
  int unsigned     starve;
  logic            exp_wen;
  logic [4:0]      exp_rd;
  logic [XLEN-1:0] exp_data;
  int              stall_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rf_wen", 64'(rf_wen), 64'(exp_wen));
    chk("rf_rd", 64'(rf_rd), 64'(exp_rd));
    chk("rf_data", rf_data, exp_data);
    chk("llu_ready", 64'(llu_ready), 64'(q.size() < 2));
    chk("llu_pending", 64'(llu_pending), 64'(q.size() != 0));
    chk("stall_pipe", 64'(stall_pipe), 64'(frc));
  endtask

  task automatic model_reset();
    q.delete();
    frc      = 1'b0;
    starve   = 0;
    exp_wen  = 1'b0;
    exp_rd   = '0;
    exp_data = '0;
  endtask

  // Evaluate the model for the inputs currently applied, advance one clock,
  // then compare against the DUT just after the edge.
  task automatic cycle();
    int          sz;
    bit          gp;
    bit          gl;
    bit          psh;
    logic [68:0] h;
    sz  = q.size();
    gp  = !frc && pipe_wen;
    gl  = (sz > 0) && (frc || !pipe_wen);
    psh = llu_valid && (sz < 2);
    exp_wen = 1'b0;
    if (gp) begin
      exp_wen  = (pipe_rd != 0);
      exp_rd   = pipe_rd;
      exp_data = pipe_data;
    end else if (gl && !flush) begin
      h        = q[0];
      exp_wen  = (h[68:64] != 0);
      exp_rd   = h[68:64];
      exp_data = h[63:0];
    end
    if (gl) void'(q.pop_front());
    if (flush) begin
      q.delete();
      starve = 0;
      frc    = 1'b0;
    end else begin
      if (psh) q.push_back({llu_rd, llu_data});
      if (frc) begin
        if (gl) starve = 0;
        if (q.size() == 0) frc = 1'b0;
      end else if (sz > 0) begin
        if (gl) starve = 0;
        else begin
          if (starve < LIM) starve++;
          if (starve == LIM && q.size() != 0) frc = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all();
    if (stall_pipe) stall_seen++;
  endtask

  task automatic idle_inputs();
    pipe_wen  = 1'b0;
    pipe_rd   = '0;
    pipe_data = '0;
    llu_valid = 1'b0;
    llu_rd    = '0;
    llu_data  = '0;
    flush     = 1'b0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    stall_seen = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Plain pipeline write.
    pipe_wen = 1'b1; pipe_rd = 5'd5; pipe_data = 64'hA5;
    cycle();
    chk("pipe_only_wen", 64'(rf_wen), 64'd1);
    chk("pipe_only_rd", 64'(rf_rd), 64'd5);
    chk("pipe_only_data", rf_data, 64'hA5);
    idle_inputs();
    cycle();

    // Single LLU result with the pipeline idle.
    llu_valid = 1'b1; llu_rd = 5'd7; llu_data = 64'h11;
    cycle();
    chk("llu_pushed", 64'(llu_pending), 64'd1);
    idle_inputs();
    cycle();
    chk("llu_write_wen", 64'(rf_wen), 64'd1);
    chk("llu_write_rd", 64'(rf_rd), 64'd7);
    chk("llu_drained", 64'(llu_pending), 64'd0);
    cycle();

    // Two pushes then continuous pipeline traffic: starvation forces drain.
    llu_valid = 1'b1; llu_rd = 5'd1; llu_data = 64'h101;
    cycle();
    pipe_wen = 1'b1; pipe_rd = 5'd9; pipe_data = 64'h99;
    llu_rd = 5'd2; llu_data = 64'h202;
    cycle();
    chk("full_not_ready", 64'(llu_ready), 64'd0);
    llu_valid = 1'b0;
    stall_seen = 0;
    repeat (8) cycle();
    chk("force_cycles", 64'(stall_seen), 64'd2);
    idle_inputs();
    cycle();

    // Push and pop in the same cycle with one entry buffered.
    llu_valid = 1'b1; llu_rd = 5'd3; llu_data = 64'h33;
    cycle();
    llu_rd = 5'd4; llu_data = 64'h44;
    cycle();
    chk("pushpop_rd", 64'(rf_rd), 64'd3);
    chk("pushpop_count1", 64'(llu_pending), 64'd1);
    idle_inputs();
    cycle();
    chk("pushpop_order", 64'(rf_rd), 64'd4);
    cycle();

    // Result for x0 is consumed but never written.
    llu_valid = 1'b1; llu_rd = 5'd0; llu_data = 64'hDEAD;
    cycle();
    idle_inputs();
    cycle();
    chk("x0_no_write", 64'(rf_wen), 64'd0);
    chk("x0_popped", 64'(llu_pending), 64'd0);
    cycle();

    // Flush with a full buffer, a same-cycle push and a pipeline write.
    pipe_wen = 1'b1; pipe_rd = 5'd9; pipe_data = 64'h9;
    llu_valid = 1'b1; llu_rd = 5'd10; llu_data = 64'hA;
    cycle();
    llu_rd = 5'd11; llu_data = 64'hB;
    cycle();
    flush = 1'b1; pipe_rd = 5'd3; pipe_data = 64'h333; llu_rd = 5'd12;
    cycle();
    chk("flush_pipe_rd", 64'(rf_rd), 64'd3);
    chk("flush_pipe_wen", 64'(rf_wen), 64'd1);
    chk("flush_empty", 64'(llu_pending), 64'd0);
    chk("flush_no_stall", 64'(stall_pipe), 64'd0);
    idle_inputs();
    repeat (3) cycle();

    // Reset in the middle of operation with entries buffered.
    llu_valid = 1'b1; pipe_wen = 1'b1; pipe_rd = 5'd8; llu_rd = 5'd13;
    repeat (2) cycle();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    idle_inputs();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    pipe_wen = 1'b1; pipe_rd = 5'd6; pipe_data = 64'h66;
    cycle();
    chk("post_reset_grant", 64'(rf_rd), 64'd6);
    idle_inputs();
    cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      pipe_wen  = ($urandom_range(0, 9) < 7);
      pipe_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      pipe_data = {$urandom, $urandom};
      llu_valid = ($urandom_range(0, 1) == 1);
      llu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      llu_data  = {$urandom, $urandom};
      flush     = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_wb_arbiter.md
RISCV_WB_ARBITER -- requirements
Module: riscv_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64, register data width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, number of consecutive lost cycles before the long-latency unit (LLU) is forced through.
REQ-003 SHALL have parameter DEPTH, fixed 2, LLU result buffer entries.
REQ-004 SHALL have port i_riscv_wbarb_clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port i_riscv_wbarb_rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port i_riscv_wbarb_pipe_wen, input, 1, in-order writeback stage requests a register write.
REQ-007 SHALL have port i_riscv_wbarb_pipe_rd, input, 5, pipeline destination register.
REQ-008 SHALL have port i_riscv_wbarb_pipe_data, input, XLEN, pipeline result (writeback mux output).
REQ-009 SHALL have port i_riscv_wbarb_llu_valid, input, 1, LLU (divider/multicycle) result valid.
REQ-010 SHALL have port i_riscv_wbarb_llu_rd, input, 5, LLU destination register.
REQ-011 SHALL have port i_riscv_wbarb_llu_data, input, XLEN, LLU result.
REQ-012 SHALL have port o_riscv_wbarb_llu_ready, output, 1, buffer can accept an LLU result.
REQ-013 SHALL have port i_riscv_wbarb_flush, input, 1, trap flush from writeback.
REQ-014 SHALL have port o_riscv_wbarb_stall_pipe, output, 1, writeback stage holds its instruction.
REQ-015 SHALL have port o_riscv_wbarb_rf_wen, output, 1, register-file write enable.
REQ-016 SHALL have port o_riscv_wbarb_rf_rd, output, 5, register-file write address.
REQ-017 SHALL have port o_riscv_wbarb_rf_data, output, XLEN, register-file write data.
REQ-018 SHALL have port o_riscv_wbarb_llu_pending, output, 1, buffer non-empty (hazard hint).

Function
REQ-019 SHALL accept (push) an LLU result when llu_valid and llu_ready are both high at a clock edge.
REQ-020 SHALL drive llu_ready = (count < 2), decoded from registered count only.
REQ-021 SHALL implement a 2-entry FIFO; head entry is the oldest push; push and pop in the same cycle SHALL keep count unchanged and preserve order.
REQ-022 SHALL use FSM states IDLE (count==0), WAIT (count>0, pipeline has priority), FORCE (LLU has priority).
REQ-023 SHALL, in IDLE/WAIT, grant the pipeline when pipe_wen is high, else grant the LLU head if count>0.
REQ-024 SHALL, in FORCE, drive stall_pipe=1 (registered state decode), ignore pipe_wen, and grant the LLU head every cycle.
REQ-025 SHALL keep a starve counter (0..STARVE_LIMIT), incremented each WAIT cycle where count>0 and the head is not granted, cleared on any head grant.
REQ-026 SHALL transition WAIT->FORCE when the counter reaches STARVE_LIMIT; FORCE->IDLE when the last entry is popped with no push that cycle; FORCE->WAIT never.
REQ-027 SHALL transition IDLE->WAIT on push, and WAIT->IDLE when count becomes 0.
REQ-028 SHALL register the granted write: rf_wen/rf_rd/rf_data valid exactly one cycle after the grant cycle.
REQ-029 SHALL suppress rf_wen for any grant with rd==0 (x0), while still popping the LLU entry.
REQ-030 SHALL, on flush, discard all buffered entries and any same-cycle push, clear the counter, and go to IDLE next cycle; a same-cycle pipeline grant SHALL still be written.
REQ-031 SHALL drive llu_pending = (count != 0).

Reset
REQ-032 SHALL, while rst_n is low, force count=0, counter=0, state=IDLE, rf_wen=0, rf_rd=0, rf_data=0, stall_pipe=0; llu_ready=1 and llu_pending=0 follow.
REQ-033 SHALL, on reset assertion mid-operation, discard buffered entries with no further rf write; the first grant is possible on the first edge after deassertion.

Verification
REQ-034 SHALL verify: pipe_wen=1 rd=5 data=0xA5 only -> next cycle rf_wen=1 rd=5 data=0xA5.
REQ-035 SHALL verify: llu push rd=7 data=0x11 with pipe idle -> pushed, granted next cycle, rf write rd=7 one cycle later, llu_pending back to 0.
REQ-036 SHALL verify: 2 LLU pushes then continuous pipe_wen -> llu_ready=0; after 4 lost cycles stall_pipe=1, both LLU writes in order on consecutive cycles, stall_pipe=0 after.
REQ-037 SHALL verify: simultaneous push and pop with count=1 -> count stays 1, order preserved.
REQ-038 SHALL verify: LLU result rd=0 -> popped, rf_wen stays 0.
REQ-039 SHALL verify: flush with count=2 plus same-cycle push and pipe_wen rd=3 -> rd=3 written, buffer empty, state IDLE, no LLU writes.
